regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-read, multi-write register file for BSV-generated designs.
//   Generalises a fixed 5-read/1-write regfile:
//   - NR read ports and NW write ports.
//   - Deterministic write-collision priority.
//   - Hardware initialisation sweep after reset, with a READY flag.
//   - Sticky out-of-range error.
//   Sits under core datapaths (GPR/CSR shadow, tag arrays) in place of the fixed-port regfile.
// PARAMETERS
//   ADDR_W    5   address width, bits
//   DATA_W    32  data width, bits
//   LO        0   lowest valid index
//   HI        31  highest valid index; HI >= LO, HI < 2**ADDR_W
//   NR        5   number of read ports, >= 1
//   NW        2   number of write ports, >= 1
//   INIT_VAL  0   DATA_W value written to every entry by the init sweep
// PORTS
//   CLK       in   1            clock, rising edge
//   RST       in   1            synchronous reset, active-high
//   WE        in   NW           per-port write enable
//   WADDR     in   NW*ADDR_W    write addresses; port k at [k*ADDR_W +: ADDR_W]
//   WDATA     in   NW*DATA_W    write data; port k at [k*DATA_W +: DATA_W]
//   RADDR     in   NR*ADDR_W    read addresses; port j at [j*ADDR_W +: ADDR_W]
//   RDATA     out  NR*DATA_W    read data; port j at [j*DATA_W +: DATA_W]
//   READY     out  1            init sweep complete; array accepts writes
//   WCOLL     out  1            registered pulse: >=2 enabled, in-range write ports hit one address
//   ERR       out  1            sticky: an out-of-range read or write address was presented
// BEHAVIOUR
//   Reset and state machine:
//   - RST=1 at a clock edge forces state INIT, clr_idx=LO, READY=0, WCOLL=0, ERR=0.
//   - INIT: each cycle arr[clr_idx] <= INIT_VAL and clr_idx++.
//     When clr_idx==HI, go to RUN on the next edge. Sweep length is HI-LO+1 cycles.
//   - RUN: READY=1. Normal operation until the next RST.
//   - RST asserted mid-sweep restarts the sweep from LO. No partial state is kept.
//   - While READY=0: all WE are ignored and every RDATA lane reads INIT_VAL.
//   Writes (RUN only):
//   - Port k writes WDATA[k] to arr[WADDR[k]] on the edge where WE[k]=1 and LO<=WADDR[k]<=HI.
//   - Collision: if several enabled, in-range ports share an address, the highest-index port wins.
//     WCOLL=1 for exactly the cycle after the collision, then 0.
//   - Out-of-range write: dropped, array unchanged, ERR <= 1.
//   Reads (RUN only):
//   - Combinational, zero latency: RDATA[j] = arr[RADDR[j]].
//   - Value is the array content as of the last edge; see CONFIGURATION for write bypass.
//   - Out-of-range read: RDATA[j] = INIT_VAL and ERR <= 1 at the next edge.
//   - ERR is only checked when READY=1. It clears only on RST.
//   Widths: address compares are unsigned on ADDR_W. No arithmetic on data.
// CONFIGURATION
//   REGFILE_MP_WR_BYPASS_EN:
//   - Defined: in RUN, if an enabled, in-range write port targets RADDR[j] in the same cycle,
//     RDATA[j] = that port's WDATA (highest-index port on collision).
//     This adds a combinational path from WDATA/WADDR/WE to RDATA.
//   - Undefined: reads return pre-edge array content. No write-to-read combinational path.
// STRUCTURE
//   Shared package regfile_mp_pkg:
//   - state typedef {INIT, RUN}.
//   - clog2 function.
//   - Lane-slice macros/functions for the packed port buses.
//   Sub-module regfile_mp_wsel:
//   - Per-entry priority encoder over NW ports.
//   - Outputs entry write enable, winning data and a collision bit.
//   - Instantiated once per entry.
//   - Its WCOLL OR-reduction and bypass muxing live in the parent.
// TESTING
//   1. RST 1 cycle, DEPTH=32 -> READY=0 for exactly 32 cycles then 1; every RDATA lane = INIT_VAL throughout.
//   2. RUN; WE=2'b01, WADDR0=3, WDATA0=0xA5A5_0003 -> next cycle RADDR0=3 returns 0xA5A5_0003; other entries unchanged.
//   3. WE=2'b11, WADDR0=WADDR1=7, WDATA0=0x11, WDATA1=0x22 -> arr[7]=0x22; WCOLL=1 for one cycle, then 0.
//   4. DEPTH=20 (LO=0,HI=19): WE0 to address 25 -> array unchanged, ERR=1 and held. RST -> ERR=0.
//   5. RST pulsed at sweep cycle 10 -> sweep restarts; READY rises 32 cycles after the second RST; writes during INIT are lost.
//   6. Same-cycle write of 0x55 to 4 with RADDR1=4 -> bypass build: RDATA1=0x55 that cycle; non-bypass build: old value, 0x55 next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// RF_LANE slices lane idx of width w out of a packed port bus.
`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV
`define RF_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package regfile_mp_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic in_range(input int unsigned a, input int unsigned lo,
                                      input int unsigned hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage
`endif

// File: rtl/regfile_mp_wsel.sv
// Per-entry write selector: picks the highest-index enabled port hitting IDX
// and flags when more than one port hits it.
module regfile_mp_wsel #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NW     = 2,
    parameter logic [ADDR_W-1:0] IDX = '0
) (
    input  logic [NW-1:0]        port_ok,
    input  logic [NW*ADDR_W-1:0] waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    output logic                 we,
    output logic [DATA_W-1:0]    data,
    output logic                 coll
);

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        we   = 1'b0;
        data = '0;
        coll = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (port_ok[k] && (`RF_LANE(waddr, k, ADDR_W) == IDX)) begin
                coll = coll | we;
                we   = 1'b1;
                data = `RF_LANE(wdata, k, DATA_W);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read/multi-write register file with init sweep, collision flag and sticky error.
// Optional same-cycle write-to-read bypass: define REGFILE_MP_WR_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter int unsigned LO       = 0,
    parameter int unsigned HI       = 31,
    parameter int          NR       = 5,
    parameter int          NW       = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NW-1:0]        WE,
    input  logic [NW*ADDR_W-1:0] WADDR,
    input  logic [NW*DATA_W-1:0] WDATA,
    input  logic [NR*ADDR_W-1:0] RADDR,
    output logic [NR*DATA_W-1:0] RDATA,
    output logic                 READY,
    output logic                 WCOLL,
    output logic                 ERR
);

    localparam logic [ADDR_W-1:0] LO_A = ADDR_W'(LO);
    localparam logic [ADDR_W-1:0] HI_A = ADDR_W'(HI);

    state_t              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic                ready_q;
    logic                wcoll_q;
    logic                err_q;

    logic [DATA_W-1:0]   arr      [LO:HI];
    logic                ent_we   [LO:HI];
    logic [DATA_W-1:0]   ent_data [LO:HI];
    logic [HI:LO]        ent_coll;

    logic [NW-1:0]       port_ok;
    logic                wr_bad;
    logic                rd_bad;

    assign READY = ready_q;
    assign WCOLL = wcoll_q;
    assign ERR   = err_q;

    // port_ok already folds in READY, so nothing downstream writes during the sweep.
    always_comb begin
        port_ok = '0;
        wr_bad  = 1'b0;
        rd_bad  = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (in_range(32'(`RF_LANE(WADDR, k, ADDR_W)), LO, HI))
                port_ok[k] = WE[k] & ready_q;
            else if (WE[k])
                wr_bad = 1'b1;
        end
        for (int j = 0; j < NR; j++) begin
            if (!in_range(32'(`RF_LANE(RADDR, j, ADDR_W)), LO, HI))
                rd_bad = 1'b1;
        end
    end

    for (genvar e = LO; e <= HI; e++) begin : g_ent
        regfile_mp_wsel #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .NW     (NW),
            .IDX    (ADDR_W'(e))
        ) u_wsel (
            .port_ok (port_ok),
            .waddr   (WADDR),
            .wdata   (WDATA),
            .we      (ent_we[e]),
            .data    (ent_data[e]),
            .coll    (ent_coll[e])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= INIT;
            clr_idx <= LO_A;
            ready_q <= 1'b0;
            wcoll_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wcoll_q <= |ent_coll;
            if (ready_q && (wr_bad || rd_bad))
                err_q <= 1'b1;
            case (state)
                INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == HI_A) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    // The array itself is not reset; the sweep overwrites every entry instead.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int unsigned e = LO; e <= HI; e++) begin
                if ((state == INIT) && (clr_idx == ADDR_W'(e)))
                    arr[e] <= INIT_VAL;
                else if (ent_we[e])
                    arr[e] <= ent_data[e];
            end
        end
    end

    always_comb begin
        RDATA = '0;
        for (int j = 0; j < NR; j++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] v;
            ra = `RF_LANE(RADDR, j, ADDR_W);
            v  = INIT_VAL;
            if (ready_q && in_range(32'(ra), LO, HI)) begin
                for (int unsigned e = LO; e <= HI; e++) begin
                    if (ra == ADDR_W'(e))
                        v = arr[e];
                end
`ifdef REGFILE_MP_WR_BYPASS_EN
                for (int k = 0; k < NW; k++) begin
                    if (port_ok[k] && (`RF_LANE(WADDR, k, ADDR_W) == ra))
                        v = `RF_LANE(WDATA, k, DATA_W);
                end
`else
`endif
            end
            `RF_LANE(RDATA, j, DATA_W) = v;
        end
    end

endmodule
